// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash responder.
package spi_flash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_ID,
        ST_STAT,
        ST_IGNORE
    } state_e;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_RDID = 8'h9F;
    localparam logic [7:0] CMD_RDSR = 8'h05;

    localparam int CMD_BITS  = 8;
    localparam int ADDR_BITS = 24;
    localparam int BCNT_W    = 5;

endpackage

// File: rtl/spi_pin_sync.sv
// Oversampling synchronizer for the SPI pads plus SCK edge detection.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic ck_i,
    input  logic cs_n_i,
    input  logic di_i,
    output logic sck_rise_o,
    output logic sck_fall_o,
    output logic cs_active_o,
    output logic di_s_o
);

    logic [SYNC_STAGES-1:0] ck_q, cs_n_q, di_q;
    logic                   ck_prev_q;

    // Shift pads through the synchronizer chain; idle values are ck=0, cs_n=1, di=0.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ck_q      <= '0;
            cs_n_q    <= '1;
            di_q      <= '0;
            ck_prev_q <= 1'b0;
        end else begin
            ck_q      <= {ck_q[SYNC_STAGES-2:0], ck_i};
            cs_n_q    <= {cs_n_q[SYNC_STAGES-2:0], cs_n_i};
            di_q      <= {di_q[SYNC_STAGES-2:0], di_i};
            ck_prev_q <= ck_q[SYNC_STAGES-1];
        end
    end

    assign sck_rise_o  =  ck_q[SYNC_STAGES-1] & ~ck_prev_q;
    assign sck_fall_o  = ~ck_q[SYNC_STAGES-1] &  ck_prev_q;
    assign cs_active_o = ~cs_n_q[SYNC_STAGES-1];
    assign di_s_o      =  di_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash target answering READ / RDID / RDSR from an on-chip byte memory.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int          ADDR_W      = 16,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
    parameter logic [7:0]  STATUS      = 8'h00,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              spi_clock_clk_i,
    input  logic              spi_clock_resetn_i,
    input  logic              flash_ck_i,
    input  logic              flash_cs_n_i,
    input  logic              flash_di_i,
    output logic              flash_do_o,
    output logic              flash_do_oe_o,
    output logic              mem_rd_req_o,
    output logic [ADDR_W-1:0] mem_rd_addr_o,
    input  logic              mem_rd_valid_i,
    input  logic [7:0]        mem_rd_data_i,
    output logic              underrun_o
);

    logic sck_rise, sck_fall, cs_active, di_s;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i       (spi_clock_clk_i),
        .rst_n_i     (spi_clock_resetn_i),
        .ck_i        (flash_ck_i),
        .cs_n_i      (flash_cs_n_i),
        .di_i        (flash_di_i),
        .sck_rise_o  (sck_rise),
        .sck_fall_o  (sck_fall),
        .cs_active_o (cs_active),
        .di_s_o      (di_s)
    );

    state_e              state_q, state_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;     // input bits seen in CMD/ADDR
    logic [2:0]          ocnt_q, ocnt_d;     // output bit position; 0 = next fall loads a byte
    logic [23:0]         in_q, in_d;
    logic [23:0]         addr_q, addr_d;
    logic [7:0]          sr_q, sr_d;
    logic [7:0]          buf_q, buf_d;
    logic                bvld_q, bvld_d;
    logic [1:0]          idx_q, idx_d;       // JEDEC byte index, saturates at 3
    logic                do_q, do_d, oe_q, oe_d, req_q, req_d, unr_q, unr_d;
    logic [ADDR_W-1:0]   rdaddr_q, rdaddr_d;

    logic [23:0] in_shift, addr_inc;
    logic [7:0]  nb;

    assign in_shift = {in_q[22:0], di_s};
    assign addr_inc = addr_q + 24'd1;

    // Next-state logic: command/address shift-in, byte sourcing and MISO shift-out.
    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        ocnt_d   = ocnt_q;
        in_d     = in_q;
        addr_d   = addr_q;
        sr_d     = sr_q;
        buf_d    = buf_q;
        bvld_d   = bvld_q;
        idx_d    = idx_q;
        do_d     = do_q;
        oe_d     = oe_q;
        req_d    = 1'b0;
        unr_d    = unr_q;
        rdaddr_d = rdaddr_q;
        nb       = 8'hFF;

        case (state_q)
            ST_IDLE: begin
                if (cs_active) begin
                    state_d = ST_CMD;
                    bcnt_d  = '0;
                    ocnt_d  = '0;
                end
            end
            ST_CMD: begin
                if (sck_rise) begin
                    in_d   = in_shift;
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == BCNT_W'(CMD_BITS - 1)) begin
                        bcnt_d = '0;
                        case (in_shift[7:0])
                            CMD_READ: state_d = ST_ADDR;
                            CMD_RDID: begin
                                state_d = ST_ID;
                                sr_d    = JEDEC_ID[23:16];
                                idx_d   = 2'd0;
                            end
                            CMD_RDSR: begin
                                state_d = ST_STAT;
                                sr_d    = STATUS;
                            end
                            default:  state_d = ST_IGNORE;
                        endcase
                    end
                end
            end
            ST_ADDR: begin
                if (sck_rise) begin
                    in_d   = in_shift;
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == BCNT_W'(ADDR_BITS - 1)) begin
                        bcnt_d   = '0;
                        addr_d   = in_shift;
                        req_d    = 1'b1;
                        rdaddr_d = in_shift[ADDR_W-1:0];
                        bvld_d   = 1'b0;
                        state_d  = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // First bit of a byte is being sampled: the buffer is free, prefetch the next one.
                if (sck_rise && ocnt_q == 3'd1) begin
                    addr_d   = addr_inc;
                    req_d    = 1'b1;
                    rdaddr_d = addr_inc[ADDR_W-1:0];
                end
                if (sck_fall && ocnt_q == 3'd0) begin
                    if (bvld_q) begin
                        nb     = buf_q;
                        bvld_d = 1'b0;
                    end else begin
                        nb    = 8'hFF;
                        unr_d = 1'b1;
                    end
                end
                if (mem_rd_valid_i) begin
                    buf_d  = mem_rd_data_i;
                    bvld_d = 1'b1;
                end
            end
            ST_ID: begin
                if (sck_fall && ocnt_q == 3'd0) begin
                    case (idx_q)
                        2'd0:    nb = JEDEC_ID[23:16];
                        2'd1:    nb = JEDEC_ID[15:8];
                        2'd2:    nb = JEDEC_ID[7:0];
                        default: nb = 8'h00;
                    endcase
                    if (idx_q != 2'd3) idx_d = idx_q + 2'd1;
                end
            end
            ST_STAT: begin
                if (sck_fall && ocnt_q == 3'd0) nb = STATUS;
            end
            default: ;
        endcase

        // MISO changes on the falling edge; a new byte starts whenever ocnt wraps to 0.
        if (sck_fall && (state_q == ST_DATA || state_q == ST_ID || state_q == ST_STAT)) begin
            oe_d   = 1'b1;
            ocnt_d = ocnt_q + 3'd1;
            if (ocnt_q == 3'd0) begin
                do_d = nb[7];
                sr_d = {nb[6:0], 1'b0};
            end else begin
                do_d = sr_q[7];
                sr_d = {sr_q[6:0], 1'b0};
            end
        end

        // Deselect aborts everything; a late read return lands in IDLE and is dropped.
        if (state_q != ST_IDLE && !cs_active) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            do_d    = 1'b1;
            req_d   = 1'b0;
            bvld_d  = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge spi_clock_clk_i) begin
        if (!spi_clock_resetn_i) begin
            state_q  <= ST_IDLE;
            bcnt_q   <= '0;
            ocnt_q   <= '0;
            in_q     <= '0;
            addr_q   <= '0;
            sr_q     <= '0;
            buf_q    <= '0;
            bvld_q   <= 1'b0;
            idx_q    <= '0;
            do_q     <= 1'b1;
            oe_q     <= 1'b0;
            req_q    <= 1'b0;
            unr_q    <= 1'b0;
            rdaddr_q <= '0;
        end else begin
            state_q  <= state_d;
            bcnt_q   <= bcnt_d;
            ocnt_q   <= ocnt_d;
            in_q     <= in_d;
            addr_q   <= addr_d;
            sr_q     <= sr_d;
            buf_q    <= buf_d;
            bvld_q   <= bvld_d;
            idx_q    <= idx_d;
            do_q     <= do_d;
            oe_q     <= oe_d;
            req_q    <= req_d;
            unr_q    <= unr_d;
            rdaddr_q <= rdaddr_d;
        end
    end

    assign flash_do_o    = do_q;
    assign flash_do_oe_o = oe_q;
    assign mem_rd_req_o  = req_q;
    assign mem_rd_addr_o = rdaddr_q;
    assign underrun_o    = unr_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: SPI master model plus a 2-cycle memory model.
module tb_spi_flash_responder;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ck = 1'b0, cs_n = 1'b1, di = 1'b0;
    logic        fdo, foe, req, vld, unr;
    logic [15:0] raddr;
    logic [7:0]  rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic        mem_en = 1'b1;
    logic [1:0]  vpipe;
    logic [7:0]  d0, d1;
    logic [15:0] alog[$];
    logic [7:0]  rxb[8];
    logic        oe_seen;

    always #5 clk = ~clk;

    spi_flash_responder dut (
        .spi_clock_clk_i    (clk),
        .spi_clock_resetn_i (resetn),
        .flash_ck_i         (ck),
        .flash_cs_n_i       (cs_n),
        .flash_di_i         (di),
        .flash_do_o         (fdo),
        .flash_do_oe_o      (foe),
        .mem_rd_req_o       (req),
        .mem_rd_addr_o      (raddr),
        .mem_rd_valid_i     (vld),
        .mem_rd_data_i      (rdata),
        .underrun_o         (unr)
    );

    // Memory model: data = addr[7:0]^A5, valid two cycles after the strobe.
    always @(posedge clk) begin
        if (!resetn) begin
            vpipe <= 2'b00;
            d0    <= 8'h00;
            d1    <= 8'h00;
        end else begin
            vpipe <= {vpipe[0], req & mem_en};
            d0    <= raddr[7:0] ^ 8'hA5;
            d1    <= d0;
            if (req) alog.push_back(raddr);
        end
    end
    assign vld   = vpipe[1];
    assign rdata = d1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SPI byte, SCK = clk/8; MISO is sampled just before each rising edge.
    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            di = tx[i];
            tick(4);
            rx[i] = fdo;
            oe_seen |= foe;
            ck = 1'b1;
            tick(4);
            ck = 1'b0;
        end
    endtask

    task automatic spi_begin();
        oe_seen = 1'b0;
        cs_n = 1'b0;
        tick(4);
    endtask

    task automatic spi_end();
        ck = 1'b0;
        tick(2);
        cs_n = 1'b1;
        tick(8);
    endtask

    task automatic send_cmd_addr(input logic [7:0] cmd, input logic [23:0] a);
        logic [7:0] junk;
        spi_byte(cmd, junk);
        spi_byte(a[23:16], junk);
        spi_byte(a[15:8], junk);
        spi_byte(a[7:0], junk);
    endtask

    task automatic read_bytes(input logic [23:0] a, input int n);
        alog.delete();
        spi_begin();
        send_cmd_addr(8'h03, a);
        for (int i = 0; i < n; i++) spi_byte(8'h00, rxb[i]);
        spi_end();
    endtask

    task automatic cmd_bytes(input logic [7:0] cmd, input int n);
        logic [7:0] junk;
        spi_begin();
        spi_byte(cmd, junk);
        for (int i = 0; i < n; i++) spi_byte(8'h00, rxb[i]);
        spi_end();
    endtask

    initial begin
        // Reset with the bus active and SCK toggling.
        resetn = 1'b0;
        cs_n   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("rst_oe", foe, 1'b0);
            chk("rst_do", fdo, 1'b1);
            chk("rst_req", req, 1'b0);
            chk("rst_unr", unr, 1'b0);
            chk("rst_addr", raddr, 16'h0000);
            ck = ~ck;
        end
        ck = 1'b0;
        cs_n = 1'b1;
        tick(2);
        resetn = 1'b1;
        tick(6);

        // READ 0x001234, four bytes.
        read_bytes(24'h001234, 4);
        chk("rd_b0", rxb[0], 8'h91);
        chk("rd_b1", rxb[1], 8'h90);
        chk("rd_b2", rxb[2], 8'h93);
        chk("rd_b3", rxb[3], 8'h92);
        chk("rd_nreq", 32'(alog.size() >= 4), 1);
        chk("rd_a0", alog[0], 16'h1234);
        chk("rd_a1", alog[1], 16'h1235);
        chk("rd_a2", alog[2], 16'h1236);
        chk("rd_a3", alog[3], 16'h1237);
        chk("rd_unr", unr, 1'b0);
        chk("rd_idle_oe", foe, 1'b0);
        chk("rd_idle_do", fdo, 1'b1);

        // Address wrap within ADDR_W.
        read_bytes(24'h00FFFF, 2);
        chk("wr_a0", alog[0], 16'hFFFF);
        chk("wr_a1", alog[1], 16'h0000);
        chk("wr_b0", rxb[0], 8'h5A);
        chk("wr_b1", rxb[1], 8'hA5);

        // JEDEC ID.
        cmd_bytes(8'h9F, 5);
        chk("id_b0", rxb[0], 8'hEF);
        chk("id_b1", rxb[1], 8'h40);
        chk("id_b2", rxb[2], 8'h16);
        chk("id_b3", rxb[3], 8'h00);
        chk("id_b4", rxb[4], 8'h00);

        // Status register.
        cmd_bytes(8'h05, 2);
        chk("st_b0", rxb[0], 8'h00);
        chk("st_b1", rxb[1], 8'h00);
        chk("st_oe", oe_seen, 1'b1);

        // Unknown command keeps the pad tristated.
        cmd_bytes(8'hAB, 2);
        chk("ign_oe", oe_seen, 1'b0);

        // Abort after three data bits.
        spi_begin();
        send_cmd_addr(8'h03, 24'h001234);
        for (int i = 0; i < 3; i++) begin
            tick(4);
            ck = 1'b1;
            tick(4);
            ck = 1'b0;
        end
        chk("ab_oe_on", foe, 1'b1);
        cs_n = 1'b1;
        tick(4);
        chk("ab_oe", foe, 1'b0);
        chk("ab_do", fdo, 1'b1);
        tick(6);
        read_bytes(24'h000010, 1);
        chk("ab_a0", alog[0], 16'h0010);
        chk("ab_b0", rxb[0], 8'hB5);
        chk("ab_unr", unr, 1'b0);

        // Memory never answers: underrun, sticky until reset.
        mem_en = 1'b0;
        read_bytes(24'h000020, 1);
        chk("ur_b0", rxb[0], 8'hFF);
        chk("ur_flag", unr, 1'b1);
        tick(20);
        chk("ur_sticky", unr, 1'b1);
        mem_en = 1'b1;
        resetn = 1'b0;
        tick(2);
        resetn = 1'b1;
        tick(2);
        chk("ur_clr", unr, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
